trace_nop_event_collector: RTL and testbench



---
 rtl/trace_event_pkg.sv | 43 ++++
 rtl/trace_event_fifo.sv | 68 ++++++
 rtl/trace_nop_event_collector.sv | 108 ++++++++++
 tb/tb_trace_nop_event_collector.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/trace_event_pkg.sv
// Shared types and constants for the l.nop trace event collector.
package trace_event_pkg;

    localparam logic [7:0]  NOP_OPCODE = 8'h15;
    localparam logic [15:0] NOP_EXIT   = 16'h0001;
    localparam logic [15:0] NOP_REPORT = 16'h0002;
    localparam logic [15:0] NOP_PUTC   = 16'h0004;

    typedef enum logic [1:0] {
        EV_EXIT   = 2'd0,
        EV_REPORT = 2'd1,
        EV_PUTC   = 2'd2,
        EV_USER   = 2'd3
    } event_type_e;

    // One queued event: 2 + 16 + 32 + 32 = 82 bits.
    typedef struct packed {
        event_type_e ev_type;
        logic [15:0] code;
        logic [31:0] value;
        logic [31:0] pc;
    } event_rec_t;

    localparam int EVENT_REC_W = $bits(event_rec_t);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TERM = 1'b1
    } collector_state_e;

    // Maps a nonzero nop K field to its event class; unknown codes are USER.
    function automatic event_type_e classify_nop(input logic [15:0] k);
        event_type_e t;
        case (k)
            NOP_EXIT:   t = EV_EXIT;
            NOP_REPORT: t = EV_REPORT;
            NOP_PUTC:   t = EV_PUTC;
            default:    t = EV_USER;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/trace_event_fifo.sv
// Generic synchronous FIFO with a valid/ready read side and a push-accept
// output. A push into a full FIFO is accepted only when a pop happens in the
// same cycle; an empty FIFO never bypasses, so data appears a cycle later.
module trace_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 82
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_accept,
    output logic             full,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             empty;
    logic             pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign out_valid   = !empty;
    assign pop         = out_valid && out_ready;
    assign push_accept = push_valid && (!full || pop);
    assign out_data    = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state for storage and pointers from the push/pop decisions.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_accept) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Register storage and pointers; reset clears contents so outputs read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/trace_nop_event_collector.sv
// Watches one core's retirement trace, shadows r3, turns simulation l.nop K
// instructions into event records and queues them for a downstream consumer.
module trace_nop_event_collector
    import trace_event_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trace_enable,
    input  logic [31:0]          trace_pc,
    input  logic [31:0]          trace_insn,
    input  logic                 trace_wben,
    input  logic [4:0]           trace_wbreg,
    input  logic [31:0]          trace_wbdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           out_type,
    output logic [15:0]          out_code,
    output logic [31:0]          out_value,
    output logic [31:0]          out_pc,
    output logic                 terminated,
    output logic [CNT_WIDTH-1:0] drop_count
);

    collector_state_e     state_q, state_d;
    logic [31:0]          r3_q, r3_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;

    logic                 in_run;
    logic [15:0]          nop_k;
    logic                 is_event;
    event_rec_t           ev_rec;
    event_rec_t           head_rec;
    logic                 push_accept;
    logic                 fifo_full_unused;
    logic                 insn_bits_unused;

    // The reserved middle byte of an l.nop carries no meaning here.
    assign insn_bits_unused = ^trace_insn[23:16];

    assign in_run   = (state_q == ST_RUN);
    assign nop_k    = trace_insn[15:0];
    assign is_event = in_run && trace_enable &&
                      (trace_insn[31:24] == NOP_OPCODE) && (nop_k != 16'h0000);

    // Build the record; value is the r3 shadow before any same-cycle write.
    always_comb begin
        ev_rec         = '0;
        ev_rec.ev_type = classify_nop(nop_k);
        ev_rec.code    = nop_k;
        ev_rec.value   = r3_q;
        ev_rec.pc      = trace_pc;
    end

    // Shadow r3, termination FSM and saturating drop counter next-state.
    always_comb begin
        state_d = state_q;
        r3_d    = r3_q;
        drop_d  = drop_q;
        if (in_run && trace_enable && trace_wben && (trace_wbreg == 5'd3)) begin
            r3_d = trace_wbdata;
        end
        if (is_event && (ev_rec.ev_type == EV_EXIT)) begin
            state_d = ST_TERM;
        end
        if (is_event && !push_accept && (drop_q != {CNT_WIDTH{1'b1}})) begin
            drop_d = drop_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // State registers; TERM is only left through reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            r3_q    <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            r3_q    <= r3_d;
            drop_q  <= drop_d;
        end
    end

    trace_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVENT_REC_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_valid  (is_event),
        .push_data   (ev_rec),
        .push_accept (push_accept),
        .full        (fifo_full_unused),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (head_rec)
    );

    assign out_type   = head_rec.ev_type;
    assign out_code   = head_rec.code;
    assign out_value  = head_rec.value;
    assign out_pc     = head_rec.pc;
    assign terminated = (state_q == ST_TERM);
    assign drop_count = drop_q;

endmodule

// File: tb/tb_trace_nop_event_collector.sv
// Directed self-checking bench for the l.nop trace event collector.
module tb_trace_nop_event_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_enable;
    logic [31:0] trace_pc;
    logic [31:0] trace_insn;
    logic        trace_wben;
    logic [4:0]  trace_wbreg;
    logic [31:0] trace_wbdata;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_type;
    logic [15:0] out_code;
    logic [31:0] out_value;
    logic [31:0] out_pc;
    logic        terminated;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trace_nop_event_collector #(
        .FIFO_DEPTH (4),
        .CNT_WIDTH  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trace_enable (trace_enable),
        .trace_pc     (trace_pc),
        .trace_insn   (trace_insn),
        .trace_wben   (trace_wben),
        .trace_wbreg  (trace_wbreg),
        .trace_wbdata (trace_wbdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_type     (out_type),
        .out_code     (out_code),
        .out_value    (out_value),
        .out_pc       (out_pc),
        .terminated   (terminated),
        .drop_count   (drop_count)
    );

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_trace();
        trace_enable = 1'b0;
        trace_pc     = 32'h0;
        trace_insn   = 32'h0;
        trace_wben   = 1'b0;
        trace_wbreg  = 5'd0;
        trace_wbdata = 32'h0;
    endtask

    task automatic retire_wr(input logic [4:0] r, input logic [31:0] d);
        trace_enable = 1'b1;
        trace_insn   = 32'hE060_0004;
        trace_wben   = 1'b1;
        trace_wbreg  = r;
        trace_wbdata = d;
        step();
        idle_trace();
    endtask

    task automatic retire_nop(input logic [31:0] pc, input logic [15:0] k);
        trace_enable = 1'b1;
        trace_pc     = pc;
        trace_insn   = {8'h15, 8'h00, k};
        step();
        idle_trace();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        idle_trace();
        step();
        step();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b exp=0", out_valid); end
        total++; if (out_type !== 2'd0) begin bad++; $display("[TB] FAIL reset_type got=%0d exp=0", out_type); end
        total++; if (out_code !== 16'h0) begin bad++; $display("[TB] FAIL reset_code got=%h exp=0", out_code); end
        total++; if (out_value !== 32'h0) begin bad++; $display("[TB] FAIL reset_value got=%h exp=0", out_value); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc got=%h exp=0", out_pc); end
        total++; if (terminated !== 1'b0) begin bad++; $display("[TB] FAIL reset_term got=%0b exp=0", terminated); end
        total++; if (drop_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_drop got=%0d exp=0", drop_count); end
    endtask

    task automatic test_putc();
        out_ready = 1'b1;
        retire_wr(5'd3, 32'h41);
        retire_nop(32'h100, 16'h0004);
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL putc_valid got=%0b exp=1", out_valid); end
        total++; if (out_type !== 2'd2) begin bad++; $display("[TB] FAIL putc_type got=%0d exp=2", out_type); end
        total++; if (out_code !== 16'h0004) begin bad++; $display("[TB] FAIL putc_code got=%h exp=0004", out_code); end
        total++; if (out_value !== 32'h41) begin bad++; $display("[TB] FAIL putc_value got=%h exp=41", out_value); end
        total++; if (out_pc !== 32'h100) begin bad++; $display("[TB] FAIL putc_pc got=%h exp=100", out_pc); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL putc_one_cycle got=%0b exp=0", out_valid); end
    endtask

    task automatic test_plain_nop();
        retire_nop(32'h104, 16'h0000);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL plain_nop_valid got=%0b exp=0", out_valid); end
        out_ready = 1'b0;
        retire_wr(5'd3, 32'h5);
        retire_nop(32'h108, 16'h0002);
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL report_valid got=%0b exp=1", out_valid); end
        total++; if (out_type !== 2'd1) begin bad++; $display("[TB] FAIL report_type got=%0d exp=1", out_type); end
        total++; if (out_value !== 32'h5) begin bad++; $display("[TB] FAIL report_value got=%h exp=5", out_value); end
        retire_wr(5'd3, 32'h6);
        total++; if (out_value !== 32'h5) begin bad++; $display("[TB] FAIL report_hold_value got=%h exp=5", out_value); end
        total++; if (out_pc !== 32'h108) begin bad++; $display("[TB] FAIL report_hold_pc got=%h exp=108", out_pc); end
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL report_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_same_cycle_wb();
        out_ready = 1'b0;
        trace_enable = 1'b1;
        trace_pc     = 32'h110;
        trace_insn   = 32'h1500_0010;
        trace_wben   = 1'b1;
        trace_wbreg  = 5'd3;
        trace_wbdata = 32'h7;
        step();
        idle_trace();
        retire_nop(32'h114, 16'h0020);
        total++; if (out_type !== 2'd3) begin bad++; $display("[TB] FAIL user_type got=%0d exp=3", out_type); end
        total++; if (out_code !== 16'h0010) begin bad++; $display("[TB] FAIL user_code got=%h exp=0010", out_code); end
        total++; if (out_value !== 32'h6) begin bad++; $display("[TB] FAIL wb_same_cycle_value got=%h exp=6", out_value); end
        out_ready = 1'b1;
        step();
        total++; if (out_value !== 32'h7) begin bad++; $display("[TB] FAIL wb_after_value got=%h exp=7", out_value); end
        total++; if (out_pc !== 32'h114) begin bad++; $display("[TB] FAIL user2_pc got=%h exp=114", out_pc); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL user_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) retire_nop(32'h200 + 32'(4 * i), 16'h0004);
        total++; if (drop_count !== 16'd2) begin bad++; $display("[TB] FAIL overflow_drop got=%0d exp=2", drop_count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL overflow_valid[%0d] got=%0b exp=1", i, out_valid); end
            total++; if (out_pc !== 32'h200 + 32'(4 * i)) begin bad++; $display("[TB] FAIL overflow_pc[%0d] got=%h exp=%h", i, out_pc, 32'h200 + 32'(4 * i)); end
            step();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL overflow_empty got=%0b exp=0", out_valid); end
    endtask

    task automatic test_full_pop();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) retire_nop(32'h300 + 32'(4 * i), 16'h0004);
        trace_enable = 1'b1;
        trace_pc     = 32'h310;
        trace_insn   = 32'h1500_0004;
        out_ready    = 1'b1;
        step();
        idle_trace();
        total++; if (drop_count !== 16'd2) begin bad++; $display("[TB] FAIL full_pop_drop got=%0d exp=2", drop_count); end
        for (int i = 0; i < 4; i++) begin
            total++; if (out_pc !== 32'h304 + 32'(4 * i)) begin bad++; $display("[TB] FAIL full_pop_pc[%0d] got=%h exp=%h", i, out_pc, 32'h304 + 32'(4 * i)); end
            step();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL full_pop_empty got=%0b exp=0", out_valid); end
    endtask

    task automatic test_terminate();
        out_ready = 1'b0;
        retire_wr(5'd3, 32'h0);
        retire_nop(32'h400, 16'h0004);
        retire_nop(32'h404, 16'h0004);
        total++; if (terminated !== 1'b0) begin bad++; $display("[TB] FAIL pre_exit_term got=%0b exp=0", terminated); end
        retire_nop(32'h408, 16'h0001);
        total++; if (terminated !== 1'b1) begin bad++; $display("[TB] FAIL exit_term got=%0b exp=1", terminated); end
        retire_wr(5'd3, 32'h99);
        for (int i = 0; i < 3; i++) retire_nop(32'h40C + 32'(4 * i), 16'h0004);
        total++; if (drop_count !== 16'd2) begin bad++; $display("[TB] FAIL term_drop got=%0d exp=2", drop_count); end
        total++; if (out_pc !== 32'h400) begin bad++; $display("[TB] FAIL term_head_pc got=%h exp=400", out_pc); end
        total++; if (terminated !== 1'b1) begin bad++; $display("[TB] FAIL term_sticky got=%0b exp=1", terminated); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_valid got=%0b exp=0", out_valid); end
        total++; if (terminated !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_term got=%0b exp=0", terminated); end
        total++; if (drop_count !== 16'd0) begin bad++; $display("[TB] FAIL mid_reset_drop got=%0d exp=0", drop_count); end
        out_ready = 1'b1;
        retire_wr(5'd3, 32'h77);
        retire_nop(32'h500, 16'h0004);
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_valid got=%0b exp=1", out_valid); end
        total++; if (out_type !== 2'd2) begin bad++; $display("[TB] FAIL post_reset_type got=%0d exp=2", out_type); end
        total++; if (out_value !== 32'h77) begin bad++; $display("[TB] FAIL post_reset_value got=%h exp=77", out_value); end
        total++; if (out_pc !== 32'h500) begin bad++; $display("[TB] FAIL post_reset_pc got=%h exp=500", out_pc); end
        step();
        retire_wr(5'd3, 32'h0);
        retire_nop(32'h600, 16'h0001);
        total++; if (out_type !== 2'd0) begin bad++; $display("[TB] FAIL exit_type got=%0d exp=0", out_type); end
        total++; if (out_code !== 16'h0001) begin bad++; $display("[TB] FAIL exit_code got=%h exp=0001", out_code); end
        total++; if (out_value !== 32'h0) begin bad++; $display("[TB] FAIL exit_value got=%h exp=0", out_value); end
        total++; if (out_pc !== 32'h600) begin bad++; $display("[TB] FAIL exit_pc got=%h exp=600", out_pc); end
        total++; if (terminated !== 1'b1) begin bad++; $display("[TB] FAIL exit2_term got=%0b exp=1", terminated); end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        idle_trace();
        test_reset();
        test_putc();
        test_plain_nop();
        test_same_cycle_wb();
        test_overflow();
        test_full_pop();
        test_terminate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
